// File: rtl/note_tone_gen_if.sv
// Note bus between the note sequencer and the tone generator: note code and
// mute control in, speaker drive and status out.
interface note_tone_gen_if;
  logic       enable;
  logic [3:0] note_in;
  logic       speaker;
  logic       active;
  logic [3:0] cur_note;

  modport master (
    output enable,
    output note_in,
    input  speaker,
    input  active,
    input  cur_note
  );

  modport slave (
    input  enable,
    input  note_in,
    output speaker,
    output active,
    output cur_note
  );
endinterface

// File: rtl/note_tone_gen.sv
// Square-wave tone generator: re-times and debounces the 4-bit note bus, then
// toggles the speaker every H cycles, switching pitch only on half-period boundaries.
module note_tone_gen #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_W         = 18,
  parameter int H_SHIFT       = 0   // divides the pitch table by 2**H_SHIFT; 0 in silicon
) (
  input  logic           CLK,
  input  logic           RESET,
  note_tone_gen_if.slave bus
);

  // state | meaning
  // IDLE  | speaker held low, phase counter cleared
  // PLAY  | speaker toggles every H_active cycles
  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

  localparam int                STAB_W    = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [STAB_W-1:0] STAB_MAX  = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [3:0]        NOTE_NONE = 4'h8;

  function automatic logic [CNT_W-1:0] h_of(input logic [2:0] code);
    logic [CNT_W-1:0] h;
    h = '0;
    case (code)
      3'd0: h = CNT_W'(95557  >> H_SHIFT);
      3'd1: h = CNT_W'(101239 >> H_SHIFT);
      3'd2: h = CNT_W'(113636 >> H_SHIFT);
      3'd3: h = CNT_W'(127551 >> H_SHIFT);
      3'd4: h = CNT_W'(143172 >> H_SHIFT);
      3'd5: h = CNT_W'(151686 >> H_SHIFT);
      3'd6: h = CNT_W'(170265 >> H_SHIFT);
      3'd7: h = CNT_W'(191110 >> H_SHIFT);
      default: h = '0;
    endcase
    return h;
  endfunction

  logic [SYNC_STAGES-1:0][3:0] sync_q, sync_d;
  logic [3:0]                  prev_q, prev_d;
  logic [STAB_W-1:0]           stab_q, stab_d;
  logic [3:0]                  cur_note_q, cur_note_d;
  logic                        enable_q, enable_d;
  state_t                      state_q, state_d;
  logic                        speaker_q, speaker_d;
  logic [CNT_W-1:0]            ph_cnt_q, ph_cnt_d;
  logic [2:0]                  act_code_q, act_code_d;
  logic [2:0]                  pend_code_q, pend_code_d;
  logic                        pend_vld_q, pend_vld_d;

  logic [3:0]       sync_note;
  logic             accept;
  logic             acc_pitch;
  logic             acc_stop;
  logic             en_rise;
  logic             boundary;
  logic [CNT_W-1:0] h_active;

  // Input filter: a code is accepted on the edge where its run length reaches the threshold.
  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], bus.note_in};
    sync_note = sync_q[SYNC_STAGES-1];
    prev_d    = sync_note;
    if (sync_note != prev_q) begin
      stab_d = '0;
    end else if (stab_q != STAB_MAX) begin
      stab_d = stab_q + 1'b1;
    end else begin
      stab_d = stab_q;
    end
    accept     = (stab_d == STAB_MAX) && (sync_note != cur_note_q);
    cur_note_d = accept ? sync_note : cur_note_q;
    acc_pitch  = accept && !sync_note[3];
    acc_stop   = accept && sync_note[3];
    enable_d   = bus.enable;
    en_rise    = bus.enable && !enable_q;
  end

  always_comb begin
    state_d     = state_q;
    speaker_d   = speaker_q;
    ph_cnt_d    = ph_cnt_q;
    act_code_d  = act_code_q;
    pend_code_d = pend_code_q;
    pend_vld_d  = pend_vld_q;
    h_active    = h_of(act_code_q);
    boundary    = (ph_cnt_q == h_active - 1'b1);

    case (state_q)
      IDLE: begin
        speaker_d  = 1'b0;
        ph_cnt_d   = '0;
        pend_vld_d = 1'b0;
        if (bus.enable && acc_pitch) begin
          state_d    = PLAY;
          speaker_d  = 1'b1;
          act_code_d = sync_note[2:0];
        end else if (en_rise && !acc_stop && !cur_note_q[3]) begin
          state_d    = PLAY;
          speaker_d  = 1'b1;
          act_code_d = cur_note_q[2:0];
        end
      end

      PLAY: begin
        if (!bus.enable || acc_stop) begin
          // A stop beats a coincident boundary so the pin always ends low.
          state_d    = IDLE;
          speaker_d  = 1'b0;
          ph_cnt_d   = '0;
          pend_vld_d = 1'b0;
        end else if (boundary) begin
          ph_cnt_d   = '0;
          speaker_d  = !speaker_q;
          pend_vld_d = 1'b0;
          if (acc_pitch) begin
            act_code_d = sync_note[2:0];
          end else if (pend_vld_q) begin
            act_code_d = pend_code_q;
          end
        end else begin
          ph_cnt_d = ph_cnt_q + 1'b1;
          if (acc_pitch) begin
            pend_code_d = sync_note[2:0];
            pend_vld_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d   = IDLE;
        speaker_d = 1'b0;
        ph_cnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync_q      <= {SYNC_STAGES{NOTE_NONE}};
      prev_q      <= NOTE_NONE;
      stab_q      <= '0;
      cur_note_q  <= NOTE_NONE;
      enable_q    <= 1'b0;
      state_q     <= IDLE;
      speaker_q   <= 1'b0;
      ph_cnt_q    <= '0;
      act_code_q  <= '0;
      pend_code_q <= '0;
      pend_vld_q  <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      prev_q      <= prev_d;
      stab_q      <= stab_d;
      cur_note_q  <= cur_note_d;
      enable_q    <= enable_d;
      state_q     <= state_d;
      speaker_q   <= speaker_d;
      ph_cnt_q    <= ph_cnt_d;
      act_code_q  <= act_code_d;
      pend_code_q <= pend_code_d;
      pend_vld_q  <= pend_vld_d;
    end
  end

  assign bus.speaker  = speaker_q;
  assign bus.active   = (state_q == PLAY);
  assign bus.cur_note = cur_note_q;

endmodule
